// File: rtl/simple_mem_arb_if.sv
// Requester-side bundle for simple_mem_arb: request, write data, grant and read return.
// The requester holds the master modport; the arbiter holds the slave modport.
interface simple_mem_arb_if #(
  parameter int AW    = 8,
  parameter int WIDTH = 8
);
  logic             req;
  logic             wen;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, wen, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/simple_mem_arb.sv
// Two-requester arbiter and zero-fill sequencer in front of one single-port simple_mem.
// Optional macro SIMPLE_MEM_ARB_FIXED_PRIO_EN: A always wins on contention (no round-robin pointer).
module simple_mem_arb #(
  parameter int               WORDS     = 256,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  localparam int              AW        = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_start_i,
  output logic             clear_busy_o,
  simple_mem_arb_if.slave  a_io,
  simple_mem_arb_if.slave  b_io,
  output logic             mem_wen_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic          run;
  logic          grant_a;
  logic          grant_b;

  // Reset gates every output combinationally so nothing leaks out while rst is held.
  assign run = (state_q == ST_RUN) && !rst;

`ifdef SIMPLE_MEM_ARB_FIXED_PRIO_EN
  assign grant_a = run && a_io.req;
  assign grant_b = run && b_io.req && !a_io.req;
`else
  logic rr_q, rr_d;

  // rr_q == 0 means A wins the next contention.
  assign grant_a = run && a_io.req && (!b_io.req || !rr_q);
  assign grant_b = run && b_io.req && (!a_io.req ||  rr_q);

  always_comb begin
    rr_d = rr_q;
    if (grant_a) begin
      rr_d = 1'b1;
    end else if (grant_b) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (clear_start_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // A read granted in the last RUN cycle still returns data in the first CLEAR cycle.
  assign a_rvalid_d = grant_a && !a_io.wen;
  assign b_rvalid_d = grant_b && !b_io.wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  always_comb begin
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_wen_o   = 1'b1;
        mem_addr_o  = cnt_q;
        mem_wdata_o = CLEAR_VAL;
      end else if (grant_a) begin
        mem_wen_o   = a_io.wen;
        mem_addr_o  = a_io.addr;
        mem_wdata_o = a_io.wdata;
      end else if (grant_b) begin
        mem_wen_o   = b_io.wen;
        mem_addr_o  = b_io.addr;
        mem_wdata_o = b_io.wdata;
      end
    end
  end

  assign clear_busy_o = rst || (state_q == ST_CLEAR);

  assign a_io.ready  = grant_a;
  assign b_io.ready  = grant_b;
  assign a_io.rvalid = a_rvalid_q && !rst;
  assign b_io.rvalid = b_rvalid_q && !rst;
  assign a_io.rdata  = mem_rdata_i;
  assign b_io.rdata  = mem_rdata_i;

  a_grant_onehot: assert property (@(posedge clk) !(grant_a && grant_b));

endmodule

// File: tb/tb_simple_mem_arb.sv
// Directed bench for simple_mem_arb (WORDS=16): reset sweep, table of RUN-mode accesses,
// then clear_start and mid-sweep reset sequences against a registered-read memory model.
module tb_simple_mem_arb;
  localparam int          WORDS = 16;
  localparam int          WIDTH = 8;
  localparam int          AW    = 4;
  localparam logic [7:0]  CV    = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_start;
  logic             clear_busy;
  logic             mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] mem [WORDS];

  int n_chk = 0;
  int n_err = 0;

  simple_mem_arb_if #(.AW(AW), .WIDTH(WIDTH)) a_if ();
  simple_mem_arb_if #(.AW(AW), .WIDTH(WIDTH)) b_if ();

  simple_mem_arb #(.WORDS(WORDS), .WIDTH(WIDTH), .CLEAR_VAL(CV)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_start_i (clear_start),
    .clear_busy_o  (clear_busy),
    .a_io          (a_if),
    .b_io          (b_if),
    .mem_wen_o     (mem_wen),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port memory with registered read
  always_ff @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic ar; logic aw; logic [3:0] aa; logic [7:0] ad;
    logic br; logic bw; logic [3:0] ba; logic [7:0] bd;
    logic cs;
    logic e_ardy; logic e_brdy; logic e_arv; logic e_brv; logic e_wen;
    logic [3:0] e_addr; logic [7:0] e_wd; logic [7:0] e_ard; logic [7:0] e_brd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ar, aw, input logic [3:0] aa, input logic [7:0] ad,
    input logic br, bw, input logic [3:0] ba, input logic [7:0] bd, input logic cs,
    input logic e_ardy, e_brdy, e_arv, e_brv, e_wen,
    input logic [3:0] e_addr, input logic [7:0] e_wd, e_ard, e_brd);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd; v.cs = cs;
    v.e_ardy = e_ardy; v.e_brdy = e_brdy; v.e_arv = e_arv; v.e_brv = e_brv;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_wd = e_wd; v.e_ard = e_ard; v.e_brd = e_brd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ar, aw, input logic [3:0] aa, input logic [7:0] ad,
                       input logic br, bw, input logic [3:0] ba, input logic [7:0] bd,
                       input logic cs);
    a_if.req = ar; a_if.wen = aw; a_if.addr = aa; a_if.wdata = ad;
    b_if.req = br; b_if.wen = bw; b_if.addr = ba; b_if.wdata = bd;
    clear_start = cs;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sweep(input int i, input string tag);
    chk({tag, "_wen"},   mem_wen, 1'b1);
    chk({tag, "_addr"},  mem_addr, i);
    chk({tag, "_wdata"}, mem_wdata, CV);
    chk({tag, "_busy"},  clear_busy, 1'b1);
    chk({tag, "_ardy"},  a_if.ready, 1'b0);
    chk({tag, "_brdy"},  b_if.ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset and initial sweep ----------------
    rst = 1'b1;
    drive(1, 0, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00, 1);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_ardy", a_if.ready, 1'b0);
      chk("rst_brdy", b_if.ready, 1'b0);
      chk("rst_arv",  a_if.rvalid, 1'b0);
      chk("rst_brv",  b_if.rvalid, 1'b0);
      chk("rst_wen",  mem_wen, 1'b0);
      chk("rst_busy", clear_busy, 1'b1);
      next_cycle();
    end
    rst = 1'b0;
    drive(1, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0);
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      chk_sweep(i, "sweep1");
      next_cycle();
    end

    // ---------------- RUN-mode vector table ----------------
    tbl.push_back(mk(1,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  1,0,0,0,0, 4'd0,8'h00,8'h00,8'h00));
    tbl.push_back(mk(1,1,4'd3,8'h5A, 0,0,4'd0,8'h00, 0,  1,0,1,0,1, 4'd3,8'h5A,CV,   8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 0,0,4'd0,8'h00, 0,  1,0,0,0,0, 4'd3,8'h00,8'h00,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 1,1,4'd7,8'h77, 0,  0,1,1,0,1, 4'd7,8'h77,8'h5A,8'h00));
`ifdef SIMPLE_MEM_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,0,0,0, 4'd3,8'h00,8'h00,8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,1,0,0, 4'd3,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,1,0,0, 4'd3,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,1,0,0, 4'd3,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  0,0,1,0,0, 4'd0,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 1,0,4'd7,8'h00, 0,  0,1,0,0,0, 4'd7,8'h00,8'h00,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  0,0,0,1,0, 4'd0,8'h00,8'h00,8'h77));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,0,0,0, 4'd3,8'h00,8'h00,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  0,0,1,0,0, 4'd0,8'h00,8'h5A,8'h00));
`else
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,0,0,0, 4'd3,8'h00,8'h00,8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  0,1,1,0,0, 4'd7,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  1,0,0,1,0, 4'd3,8'h00,8'h00,8'h77));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  0,1,1,0,0, 4'd7,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  0,0,0,1,0, 4'd0,8'h00,8'h00,8'h77));
    tbl.push_back(mk(1,0,4'd3,8'h00, 0,0,4'd0,8'h00, 0,  1,0,0,0,0, 4'd3,8'h00,8'h00,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  0,0,1,0,0, 4'd0,8'h00,8'h5A,8'h00));
    tbl.push_back(mk(1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 0,  0,1,0,0,0, 4'd7,8'h00,8'h00,8'h00));
    tbl.push_back(mk(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,  0,0,0,1,0, 4'd0,8'h00,8'h00,8'h77));
`endif
    // clear_start in the same cycle as a B read grant
    tbl.push_back(mk(0,0,4'd0,8'h00, 1,0,4'd7,8'h00, 1,  0,1,0,0,0, 4'd7,8'h00,8'h00,8'h00));

    foreach (tbl[n]) begin
      drive(tbl[n].ar, tbl[n].aw, tbl[n].aa, tbl[n].ad,
            tbl[n].br, tbl[n].bw, tbl[n].ba, tbl[n].bd, tbl[n].cs);
      @(negedge clk);
      chk($sformatf("v%0d_ardy", n), a_if.ready,  tbl[n].e_ardy);
      chk($sformatf("v%0d_brdy", n), b_if.ready,  tbl[n].e_brdy);
      chk($sformatf("v%0d_arv",  n), a_if.rvalid, tbl[n].e_arv);
      chk($sformatf("v%0d_brv",  n), b_if.rvalid, tbl[n].e_brv);
      chk($sformatf("v%0d_wen",  n), mem_wen,     tbl[n].e_wen);
      chk($sformatf("v%0d_busy", n), clear_busy,  1'b0);
      if (tbl[n].e_ardy || tbl[n].e_brdy)
        chk($sformatf("v%0d_addr", n), mem_addr, tbl[n].e_addr);
      if (tbl[n].e_wen)
        chk($sformatf("v%0d_wdata", n), mem_wdata, tbl[n].e_wd);
      if (tbl[n].e_arv)
        chk($sformatf("v%0d_ardata", n), a_if.rdata, tbl[n].e_ard);
      if (tbl[n].e_brv)
        chk($sformatf("v%0d_brdata", n), b_if.rdata, tbl[n].e_brd);
      next_cycle();
    end

    // ---------------- sweep after clear_start, reset at address 9 ----------------
    drive(1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 1);
    for (int i = 0; i <= 9; i++) begin
      if (i == 5) clear_start = 1'b0;
      @(negedge clk);
      if (i == 0) begin
        chk("cs_brv",   b_if.rvalid, 1'b1);
        chk("cs_brdata", b_if.rdata, 8'h77);
      end
      chk_sweep(i, "sweep2");
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wen",  mem_wen, 1'b0);
    chk("midrst_busy", clear_busy, 1'b1);
    chk("midrst_ardy", a_if.ready, 1'b0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      chk_sweep(i, "sweep3");
      next_cycle();
    end
    @(negedge clk);
    chk("post_busy", clear_busy, 1'b0);
    chk("post_ardy", a_if.ready, 1'b1);
    chk("post_addr", mem_addr, 4'd7);
    chk("post_wen",  mem_wen, 1'b0);
    next_cycle();
    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0);
    @(negedge clk);
    chk("post_arv",   a_if.rvalid, 1'b1);
    chk("post_ardata", a_if.rdata, CV);
    chk("idle_wen",   mem_wen, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("idle_arv", a_if.rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
